// File: rtl/dm_responder.sv
// Data-memory responder: fixed-latency word read / byte-masked write behind a valid/ready handshake.
// Optional write log enabled by defining DM_WRITE_LOG_EN.
module dm_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int WORDS = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt_p0;
    logic              we_p0;
    logic [31:0]       addr_p0;
    logic [31:0]       wdata_p0;
    logic [3:0]        be_p0;
    logic [31:0]       mem [WORDS];
    logic              accept;
    logic              commit;
    logic              err;
    logic [ADDR_W-1:0] word;
    logic [31:0]       old_word;
    logic [31:0]       new_word;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        end
        return m;
    endfunction

    function automatic logic addr_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);
    endfunction

    assign accept    = (state == IDLE) && req_valid;
    assign commit    = (state == WAIT) && (cnt_p0 == 4'd0);
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid)       state_nxt = WAIT;
            WAIT:    if (cnt_p0 == 4'd0)  state_nxt = RESP;
            RESP:    if (rsp_ready)       state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)                          cnt_p0 <= 4'd0;
        else if (accept)                    cnt_p0 <= 4'(LATENCY - 1);
        else if (state == WAIT && cnt_p0 != 4'd0) cnt_p0 <= cnt_p0 - 4'd1;
    end

    // request capture: the core may change its inputs right after the accept edge
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= req_we;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
            be_p0    <= req_be;
        end
    end

    // commit stage
    assign err      = addr_err(addr_p0);
    assign word     = addr_p0[ADDR_W+1:2];
    assign old_word = mem[word];
    assign new_word = merge_bytes(old_word, wdata_p0, be_p0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else if (commit && we_p0 && !err) begin
            mem[word] <= new_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_err   <= err;
            rsp_rdata <= err ? 32'h0 : (we_p0 ? new_word : old_word);
        end
    end

`ifdef DM_WRITE_LOG_EN
    logic [31:0] pc_p0;

    always_ff @(posedge clk) begin
        if (accept) pc_p0 <= req_pc;
    end

    always_ff @(posedge clk) begin
        if (!reset && commit && we_p0 && !err)
            $display("@%h: *%h <= %h", pc_p0, {addr_p0[31:2], 2'b00}, new_word);
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed spec cases, back-pressure, reset and randomized traffic
// against a word-array reference model.
module tb_dm_responder;
    localparam int ADDR_W  = 12;
    localparam int LATENCY = 2;
    localparam int WORDS   = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] refmem [WORDS];

    always #5 clk = ~clk;

    dm_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    task automatic clear_model();
        for (int i = 0; i < WORDS; i++) refmem[i] = 32'h0;
    endtask

    // Memory seen as an array of words addressed by byte address / 4.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] exp_rd, output logic exp_er);
        int unsigned idx;
        logic [31:0] w;
        if ((addr % 4) != 0 || addr >= 32'(4 * WORDS)) begin
            exp_rd = 32'h0;
            exp_er = 1'b1;
        end else begin
            idx    = addr / 4;
            w      = refmem[idx];
            exp_er = 1'b0;
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
                refmem[idx] = w;
            end
            exp_rd = w;
        end
    endtask

    // Present one request in IDLE, then scramble inputs and wait (bounded) for rsp_valid.
    task automatic start_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, output int lat);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        req_pc = $urandom;
        @(negedge clk);
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; req_pc = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_model();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b rd=%h err=%b expected 1 0 00000000 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_directed();
        logic        t_we [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 0};
        logic [31:0] t_ad [10] = '{32'h0, 32'h4, 32'h4, 32'h4, 32'h4, 32'h6, 32'h4, 32'h4, 32'h4000, 32'h3FFC};
        logic [31:0] t_wd [10] = '{32'h0, 32'h12345678, 32'h0, 32'hAABBCCDD, 32'h0, 32'h11111111,
                                   32'h0, 32'hFFFFFFFF, 32'h22222222, 32'h0};
        logic [3:0]  t_be [10] = '{4'h0, 4'hF, 4'h0, 4'h2, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0};
        logic [31:0] t_rd [10] = '{32'h0, 32'h12345678, 32'h12345678, 32'h1234CC78, 32'h1234CC78,
                                   32'h0, 32'h1234CC78, 32'h1234CC78, 32'h0, 32'h0};
        logic        t_er [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
        logic [31:0] m_rd;
        logic        m_er;
        int          lat;
        for (int k = 0; k < 10; k++) begin
            model(t_we[k], t_ad[k], t_wd[k], t_be[k], m_rd, m_er);
            start_txn(t_we[k], t_ad[k], t_wd[k], t_be[k], lat);
            checks++;
            if (lat !== LATENCY || rsp_rdata !== t_rd[k] || rsp_err !== t_er[k]) begin
                errors++;
                $display("FAIL directed[%0d] got lat=%0d rd=%h err=%b expected lat=%0d rd=%h err=%b",
                         k, lat, rsp_rdata, rsp_err, LATENCY, t_rd[k], t_er[k]);
            end
            finish_rsp();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] m_rd;
        logic        m_er;
        int          lat;
        model(1'b0, 32'h4, 32'h0, 4'h0, m_rd, m_er);
        start_txn(1'b0, 32'h4, 32'h0, 4'h0, lat);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h5A5A5A5A; req_be = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== m_rd || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d] got vld=%b rdy=%b rd=%h err=%b expected 1 0 %h 0",
                         c, rsp_valid, req_ready, rsp_rdata, rsp_err, m_rd);
            end
        end
        finish_rsp();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release got rdy=%b vld=%b expected 1 0", req_ready, rsp_valid);
        end
        model(1'b0, 32'h10, 32'h0, 4'h0, m_rd, m_er);
        start_txn(1'b0, 32'h10, 32'h0, 4'h0, lat);
        checks++;
        if (rsp_rdata !== m_rd || lat !== LATENCY) begin
            errors++;
            $display("FAIL hold_ignored_write got rd=%h lat=%0d expected %h %0d", rsp_rdata, lat, m_rd, LATENCY);
        end
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        logic [31:0] m_rd;
        logic        m_er;
        int          nrsp;
        model(1'b0, 32'h4, 32'h0, 4'h0, m_rd, m_er);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b1;
        nrsp = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                nrsp++;
                checks++;
                if (rsp_rdata !== m_rd || rsp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_data got rd=%h err=%b expected %h 0", rsp_rdata, rsp_err, m_rd);
                end
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        checks++;
        if (nrsp !== 20 / (LATENCY + 2)) begin
            errors++;
            $display("FAIL b2b_count got %0d expected %0d", nrsp, 20 / (LATENCY + 2));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b vld=%b expected 1 0", req_ready, rsp_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_quiet got vld=%b rd=%h expected 0 00000000", rsp_valid, rsp_rdata);
        end
        start_txn(1'b0, 32'h8, 32'h0, 4'h0, lat);
        checks++;
        if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || lat !== LATENCY) begin
            errors++;
            $display("FAIL reset_dropped_write got rd=%h err=%b lat=%0d expected 00000000 0 %0d",
                     rsp_rdata, rsp_err, lat, LATENCY);
        end
        finish_rsp();
        start_txn(1'b0, 32'h4, 32'h0, 4'h0, lat);
        checks++;
        if (rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_clears_mem got rd=%h expected 00000000", rsp_rdata);
        end
        finish_rsp();
        reset = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0;
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_with_req got rdy=%b vld=%b expected 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_random();
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] m_rd;
        logic        m_er;
        int          lat;
        int          sel;
        for (int k = 0; k < 60; k++) begin
            sel   = $urandom_range(0, 9);
            we    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            be    = 4'($urandom);
            if (sel == 0)      addr = {25'($urandom_range(0, 31)), 5'd0, 2'($urandom_range(1, 3))};
            else if (sel == 1) addr = $urandom | 32'h0000_4000;
            else if (sel == 2) addr = 32'h3FFC - 32'(4 * $urandom_range(0, 3));
            else               addr = {28'($urandom_range(0, 15)), 2'b00, 2'b00};
            model(we, addr, wdata, be, m_rd, m_er);
            start_txn(we, addr, wdata, be, lat);
            checks++;
            if (lat !== LATENCY || rsp_rdata !== m_rd || rsp_err !== m_er) begin
                errors++;
                $display("FAIL random[%0d] we=%b a=%h be=%h got lat=%0d rd=%h err=%b expected lat=%0d rd=%h err=%b",
                         k, we, addr, be, lat, rsp_rdata, rsp_err, LATENCY, m_rd, m_er);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            finish_rsp();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
